// File: rtl/clip_rr_pipe.sv
// clip_rr_pipe
//   Multi-flux HEVC pel clipper. Signed reconstruction sums arrive on FLUX
//   FWFT input FIFOs. A round-robin arbiter picks one flux per cycle, clips
//   the sample to [0, 2^bd-1] and places it in a single registered output
//   stage that feeds the matching output FIFO. Two saturating counters track
//   how many samples were clipped high and low.
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   i_rd_empty        per-flux input FIFO empty
//   i_rd_dout         {tag, signed sample}; the tag bits are ignored
//   o_rd_read         one-hot pop of the granted flux
//   i_wr_full         per-flux output FIFO full
//   o_wr_din          {grant tag, zero-extended clipped pel}
//   o_wr_write        push into output FIFO o_wr_din tag
//   i_bit_depth       active bit depth (0 or >DATA_WIDTH selects DATA_WIDTH)
//   i_sat_clr         synchronous clear of both counters
//   o_sat_hi_cnt      samples clipped to max
//   o_sat_lo_cnt      samples clipped to 0
module clip_rr_pipe #(
  parameter int FLUX            = 2,
  parameter int DATA_WIDTH_CLIP = 16,
  parameter int DATA_WIDTH      = 10,
  parameter int CNT_WIDTH       = 16,
  localparam int TAG_WIDTH      = (FLUX > 1) ? $clog2(FLUX) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [FLUX-1:0]                      i_rd_empty,
  input  logic [TAG_WIDTH+DATA_WIDTH_CLIP-1:0] i_rd_dout,
  output logic [FLUX-1:0]                      o_rd_read,
  input  logic [FLUX-1:0]                      i_wr_full,
  output logic [TAG_WIDTH+DATA_WIDTH-1:0]      o_wr_din,
  output logic                                 o_wr_write,
  input  logic [4:0]                           i_bit_depth,
  input  logic                                 i_sat_clr,
  output logic [CNT_WIDTH-1:0]                 o_sat_hi_cnt,
  output logic [CNT_WIDTH-1:0]                 o_sat_lo_cnt
);

  logic                  r_out_vld;
  logic [TAG_WIDTH-1:0]  r_out_tag;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [TAG_WIDTH-1:0]  r_last_grant;
  logic [CNT_WIDTH-1:0]  r_sat_hi;
  logic [CNT_WIDTH-1:0]  r_sat_lo;

  logic                  w_drain;
  logic                  w_can_accept;
  logic [FLUX-1:0]       w_elig;
  logic                  w_found;
  logic [TAG_WIDTH-1:0]  w_grant;
  logic                  w_accept;

  // Output stage: a held word only leaves when its own FIFO has room.
  assign w_drain      = r_out_vld & ~i_wr_full[r_out_tag];
  assign w_can_accept = ~r_out_vld | w_drain;
  assign w_elig       = ~i_rd_empty & ~i_wr_full;

  // Round-robin search starting just after the last granted flux.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 1; k <= FLUX; k++) begin
      idx = (int'(r_last_grant) + k) % FLUX;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_grant = TAG_WIDTH'(idx);
      end
    end
  end

  // Gated with rst so no pop is issued while the pipe is held in reset.
  assign w_accept   = w_found & w_can_accept & ~rst;
  assign o_rd_read  = w_accept ? (FLUX'(1) << w_grant) : '0;
  assign o_wr_write = w_drain;
  assign o_wr_din   = {r_out_tag, r_out_data};

  // Clip datapath.
  logic [4:0]                         w_bd;
  logic [DATA_WIDTH-1:0]              w_max;
  logic signed [DATA_WIDTH_CLIP-1:0]  w_x;
  logic signed [DATA_WIDTH_CLIP:0]    w_xe;
  logic signed [DATA_WIDTH_CLIP:0]    w_maxe;
  logic                               w_hi;
  logic                               w_lo;
  logic [DATA_WIDTH-1:0]              w_clip;
  logic                               w_unused_tag;

  assign w_unused_tag = ^i_rd_dout[TAG_WIDTH+DATA_WIDTH_CLIP-1:DATA_WIDTH_CLIP];

  assign w_bd   = (i_bit_depth == 5'd0 || i_bit_depth > 5'(DATA_WIDTH)) ?
                  5'(DATA_WIDTH) : i_bit_depth;
  assign w_max  = {DATA_WIDTH{1'b1}} >> (5'(DATA_WIDTH) - w_bd);
  assign w_x    = i_rd_dout[DATA_WIDTH_CLIP-1:0];
  // One extra bit on both sides so the compare is signed against a positive max.
  assign w_xe   = {w_x[DATA_WIDTH_CLIP-1], w_x};
  assign w_maxe = {{(DATA_WIDTH_CLIP+1-DATA_WIDTH){1'b0}}, w_max};
  assign w_lo   = w_x[DATA_WIDTH_CLIP-1];
  assign w_hi   = w_xe > w_maxe;
  assign w_clip = w_hi ? w_max : (w_lo ? '0 : w_x[DATA_WIDTH-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_vld    <= 1'b0;
      r_out_tag    <= '0;
      r_out_data   <= '0;
      r_last_grant <= TAG_WIDTH'(FLUX-1);
    end else if (w_accept) begin
      r_out_vld    <= 1'b1;
      r_out_tag    <= w_grant;
      r_out_data   <= w_clip;
      r_last_grant <= w_grant;
    end else if (w_drain) begin
      r_out_vld    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_hi <= '0;
      r_sat_lo <= '0;
    end else if (i_sat_clr) begin
      r_sat_hi <= '0;
      r_sat_lo <= '0;
    end else begin
      if (w_accept && w_hi && !(&r_sat_hi)) r_sat_hi <= r_sat_hi + 1'b1;
      if (w_accept && w_lo && !(&r_sat_lo)) r_sat_lo <= r_sat_lo + 1'b1;
    end
  end

  assign o_sat_hi_cnt = r_sat_hi;
  assign o_sat_lo_cnt = r_sat_lo;

endmodule

// File: tb/tb_clip_rr_pipe.sv
module tb_clip_rr_pipe;
  localparam int FLUX = 2;
  localparam int DWC  = 16;
  localparam int DW   = 10;
  localparam int CW   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [FLUX-1:0]  empty;
  logic [DWC:0]     dout;
  logic [FLUX-1:0]  rd;
  logic [FLUX-1:0]  full = '0;
  logic [DW:0]      din;
  logic             wr;
  logic [4:0]       bd = 5'd0;
  logic             sat_clr = 1'b0;
  logic [CW-1:0]    sat_hi, sat_lo;

  always #5 clk = ~clk;

  // Input FIFO fronts; tag bits deliberately carry the wrong flux.
  logic [DWC-1:0] f0 = '0, f1 = '0;
  assign dout = rd[1] ? {1'b0, f1} : {1'b1, f0};

  clip_rr_pipe #(.FLUX(FLUX), .DATA_WIDTH_CLIP(DWC), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .i_rd_empty(empty), .i_rd_dout(dout), .o_rd_read(rd),
    .i_wr_full(full), .o_wr_din(din), .o_wr_write(wr),
    .i_bit_depth(bd), .i_sat_clr(sat_clr),
    .o_sat_hi_cnt(sat_hi), .o_sat_lo_cnt(sat_lo)
  );

  int q0[$], q1[$];
  logic [DW:0] exp_q[$];
  int n_chk = 0, n_pass = 0;
  int mhi = 0, mlo = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic int clip(input int x, input int bdi);
    int b, mx;
    b  = (bdi == 0 || bdi > DW) ? DW : bdi;
    mx = (1 << b) - 1;
    if (x > mx) return mx;
    if (x < 0)  return 0;
    return x;
  endfunction

  task automatic upd();
    empty[0] = (q0.size() == 0);
    empty[1] = (q1.size() == 0);
    f0 = empty[0] ? '0 : DWC'(q0[0]);
    f1 = empty[1] ? '0 : DWC'(q1[0]);
  endtask

  // Monitor: compare pushes against the scoreboard, model pops and counters.
  always begin : mon
    logic [FLUX-1:0] s_rd;
    int s_bd, x, b, mx;
    logic s_clr;
    @(negedge clk);
    s_rd = rd; s_bd = int'(bd); s_clr = sat_clr;
    if (wr) begin
      if (exp_q.size() == 0) check("din_unexpected", 32'd1, 32'd0);
      else check("din", 32'(din), 32'(exp_q.pop_front()));
    end
    @(posedge clk); #1;
    if (!rst) begin
      if (s_clr) begin mhi = 0; mlo = 0; end
      for (int i = 0; i < FLUX; i++) begin
        if (s_rd[i]) begin
          if ((i == 0 ? q0.size() : q1.size()) == 0) check("pop_empty", 32'(i), 32'hffff);
          else begin
            x  = (i == 0) ? q0.pop_front() : q1.pop_front();
            b  = (s_bd == 0 || s_bd > DW) ? DW : s_bd;
            mx = (1 << b) - 1;
            exp_q.push_back({1'(i), DW'(clip(x, s_bd))});
            if (!s_clr && x > mx && mhi < (1 << CW) - 1) mhi++;
            if (!s_clr && x < 0  && mlo < (1 << CW) - 1) mlo++;
          end
        end
      end
      upd();
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic step(input string tag, input logic [1:0] erd, input logic ewr);
    @(negedge clk);
    check({tag, "_read"}, 32'(rd), 32'(erd));
    check({tag, "_write"}, 32'(wr), 32'(ewr));
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; exp_q.delete(); mhi = 0; mlo = 0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q0.size() + q1.size() + exp_q.size() != 0 || wr) && n < 100) begin
      tick(); n++;
    end
    check({tag, "_drain_pending"}, 32'(q0.size() + q1.size() + exp_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    upd();
    // Reset state, with flux0 already non-empty.
    q0.push_back(7); upd();
    repeat (2) tick();
    check("rst_write", 32'(wr), 32'd0);
    check("rst_read", 32'(rd), 32'd0);
    check("rst_din", 32'(din), 32'd0);
    check("rst_sat_hi", 32'(sat_hi), 32'd0);
    check("rst_sat_lo", 32'(sat_lo), 32'd0);
    rst = 1'b0;
    step("t1", 2'b01, 1'b0);
    drain("t1");

    // bd=8: 300,-5,128 -> 255,0,128, one cycle after each pop.
    bd = 5'd8;
    q0.push_back(300); q0.push_back(-5); q0.push_back(128); upd();
    step("t2a", 2'b01, 1'b0);
    step("t2b", 2'b01, 1'b1);
    step("t2c", 2'b01, 1'b1);
    step("t2d", 2'b00, 1'b1);
    step("t2e", 2'b00, 1'b0);
    check("t2_sat_hi", 32'(sat_hi), 32'd1);
    check("t2_sat_lo", 32'(sat_lo), 32'd1);

    // Two busy fluxes alternate, one word per cycle.
    do_reset();
    bd = 5'd10;
    for (int i = 0; i < 4; i++) begin q0.push_back(i + 1); q1.push_back(i + 11); end
    upd();
    step("t3_0", 2'b01, 1'b0);
    for (int i = 0; i < 7; i++) step("t3_n", (i % 2 == 0) ? 2'b10 : 2'b01, 1'b1);
    step("t3_x", 2'b00, 1'b1);
    step("t3_y", 2'b00, 1'b0);

    // Held word blocks everything until its FIFO frees up.
    do_reset();
    q0.push_back(50); upd();
    step("t4a", 2'b01, 1'b0);
    full[0] = 1'b1; q1.push_back(60); q1.push_back(61); upd();
    step("t4_blk0", 2'b00, 1'b0);
    step("t4_blk1", 2'b00, 1'b0);
    full[0] = 1'b0;
    step("t4_rel", 2'b10, 1'b1);
    step("t4b", 2'b10, 1'b1);
    step("t4c", 2'b00, 1'b1);
    step("t4d", 2'b00, 1'b0);

    // Bit-depth boundaries.
    bd = 5'd10; q0.push_back(1023); q0.push_back(1024); upd(); drain("t5_bd10");
    bd = 5'd0;  q0.push_back(1024); q0.push_back(5);    upd(); drain("t5_bd0");
    bd = 5'd20; q0.push_back(-1);   q0.push_back(2000); upd(); drain("t5_bd20");
    check("t5_sat_hi", 32'(sat_hi), 32'd3);
    check("t5_sat_lo", 32'(sat_lo), 32'd1);
    check("t5_model_hi", 32'(sat_hi), 32'(mhi));

    // Reset while a word is held.
    bd = 5'd8;
    q0.push_back(300); upd();
    step("t6a", 2'b01, 1'b0);
    full[0] = 1'b1; q0.push_back(5); q1.push_back(6); upd();
    step("t6_hold", 2'b00, 1'b0);
    rst = 1'b1; exp_q.delete(); mhi = 0; mlo = 0;
    #1;
    check("t6_rst_write", 32'(wr), 32'd0);
    check("t6_rst_read", 32'(rd), 32'd0);
    check("t6_rst_hi", 32'(sat_hi), 32'd0);
    full[0] = 1'b0;
    tick(); tick();
    rst = 1'b0;
    step("t6b", 2'b01, 1'b0);
    step("t6c", 2'b10, 1'b1);
    step("t6d", 2'b00, 1'b1);
    step("t6e", 2'b00, 1'b0);

    // Counter saturation and clear priority.
    sat_clr = 1'b1; tick(); sat_clr = 1'b0;
    for (int i = 0; i < 20; i++) q0.push_back(300);
    upd();
    drain("t7");
    check("t7_sat_hi", 32'(sat_hi), 32'd15);
    check("t7_model_hi", 32'(sat_hi), 32'(mhi));
    q0.push_back(300); upd(); sat_clr = 1'b1;
    tick(); sat_clr = 1'b0;
    check("t7_clr_hi", 32'(sat_hi), 32'd0);
    drain("t7b");
    check("t7b_model_hi", 32'(sat_hi), 32'(mhi));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
